// File: rtl/jtag_scan_master_if.sv
// Command/response bundle for jtag_scan_master.
//   master : issues commands (cmd_valid/op/len/data), receives cmd_ready and rsp_*
//   slave  : the scan master itself, accepts commands and returns responses
interface jtag_scan_master_if #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_err;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs one DR scan, IR scan or TAP reset per accepted command and
// returns the captured TDO bits. Shares tck with the TAP; every register is on posedge.
// Ports:
//   tck, trst   clock and synchronous active-high reset
//   bus         command/response bundle (slave side)
//   tms, tdi    registered pins to the TAP
//   tdo         TAP output, changed by the TAP on negedge
module jtag_scan_master #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic              tck,
  input  logic              trst,
  jtag_scan_master_if.slave bus,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  // Mirror of the TAP controller; only the states this master ever visits.
  typedef enum logic [3:0] {
    TapInit, TapTlr, TapIdle, TapSelDr, TapSelIr, TapCapture, TapShift, TapExit1, TapUpdate
  } tap_e;

  typedef enum logic [1:0] {OpDr = 2'd0, OpIr = 2'd1, OpReset = 2'd2, OpRsvd = 2'd3} op_e;

  localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] One      = LEN_W'(1);
  // Count value at which the fifth consecutive tms=1 is being consumed.
  localparam logic [LEN_W-1:0] OnesLast = LEN_W'(4);

  tap_e               tap_q, tap_d;
  op_e                op_q, op_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               busy_q, busy_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               cmd_ready;
  logic               cmd_bad;

  assign cmd_ready = (tap_q == TapIdle) && !busy_q && !rsp_valid_q;
  assign cmd_bad   = (bus.cmd_op == OpRsvd) || (bus.cmd_len == '0) || (bus.cmd_len > MaxLen);

  always_comb begin
    tap_d       = tap_q;
    op_d        = op_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;

    // The mirror follows the tms value currently on the pin, exactly as the TAP does.
    unique case (tap_q)
      TapInit:    tap_d = (cnt_q == OnesLast) ? TapTlr : TapInit;
      TapTlr:     tap_d = tms_q ? TapTlr : TapIdle;
      TapIdle:    tap_d = tms_q ? TapSelDr : TapIdle;
      TapSelDr:   tap_d = tms_q ? TapSelIr : TapCapture;
      TapSelIr:   tap_d = tms_q ? TapTlr : TapCapture;
      TapCapture: tap_d = tms_q ? TapExit1 : TapShift;
      TapShift:   tap_d = tms_q ? TapExit1 : TapShift;
      TapExit1:   tap_d = TapUpdate; // tms is always 1 here, Pause is never entered
      TapUpdate:  tap_d = tms_q ? TapSelDr : TapIdle;
      default:    tap_d = TapInit;
    endcase

    if (tap_q == TapInit) begin
      // Five ones reach Test-Logic-Reset from any TAP state, then one zero to idle.
      if (cnt_q == OnesLast) begin
        cnt_d = '0;
      end else begin
        tms_d = 1'b1;
        cnt_d = cnt_q + One;
      end
    end else if (!busy_q) begin
      if (cmd_ready && bus.cmd_valid) begin
        if (cmd_bad) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          tms_d  = 1'b1;
          busy_d = 1'b1;
          op_d   = op_e'(bus.cmd_op);
          cnt_d  = (bus.cmd_op == OpReset) ? '0 : bus.cmd_len;
          data_d = bus.cmd_data;
          mask_d = MAX_LEN'(1);
          cap_d  = '0;
        end
      end
    end else if (tap_d == TapIdle) begin
      busy_d      = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_data_d  = cap_q;
    end else if (op_q == OpReset) begin
      if (cnt_q == OnesLast) begin
        cnt_d = '0;
      end else begin
        tms_d = 1'b1;
        cnt_d = cnt_q + One;
      end
    end else begin
      // The TAP consumes one bit on every edge spent in Shift.
      if (tap_q == TapShift) begin
        if (tdo) begin
          cap_d = cap_q | mask_q;
        end
        mask_d = mask_q << 1;
        data_d = data_q >> 1;
        cnt_d  = cnt_q - One;
      end
      unique case (tap_d)
        TapSelDr: tms_d = (op_q == OpIr);
        TapShift: begin
          tms_d = (cnt_d == One); // last bit leaves Shift
          tdi_d = data_d[0];
        end
        TapExit1: tms_d = 1'b1;
        default:  tms_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      tap_q       <= TapInit;
      op_q        <= OpDr;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      tap_q       <= tap_d;
      op_q        <= op_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign tms           = tms_q;
  assign tdi           = tdi_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master paired with a behavioural 4-bit-IR TAP
// (IDCODE 0x12345157, USER data register, BYPASS).
module tb_jtag_scan_master;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;

  logic tck  = 1'b0;
  logic trst = 1'b1;
  logic tms;
  logic tdi;
  logic tdo  = 1'b0;

  int total = 0;
  int bad   = 0;

  jtag_scan_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus),
    .tms  (tms),
    .tdi  (tdi),
    .tdo  (tdo)
  );

  always #5 tck = ~tck;

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TsTlr, TsIdle, TsSelDr, TsCapDr, TsShDr, TsEx1Dr, TsPauseDr, TsEx2Dr, TsUpdDr,
    TsSelIr, TsCapIr, TsShIr, TsEx1Ir, TsPauseIr, TsEx2Ir, TsUpdIr
  } ts_e;

  localparam logic [3:0]  IrIdcode = 4'h1;
  localparam logic [3:0]  IrUser   = 4'h8;
  localparam logic [3:0]  IrBypass = 4'hF;
  localparam logic [31:0] Idcode   = {4'h1, 16'h2345, 11'h0AB, 1'b1};

  ts_e         ts       = TsIdle;
  logic [3:0]  ir       = IrBypass;
  logic [3:0]  ir_sr    = 4'h0;
  logic [31:0] dr_sr    = 32'h0;
  logic        byp      = 1'b0;
  logic [31:0] user_in  = 32'h0BADF00D;
  logic [31:0] user_out = 32'h0;

  function automatic ts_e ts_next(input ts_e s, input logic m);
    case (s)
      TsTlr:     return m ? TsTlr   : TsIdle;
      TsIdle:    return m ? TsSelDr : TsIdle;
      TsSelDr:   return m ? TsSelIr : TsCapDr;
      TsCapDr:   return m ? TsEx1Dr : TsShDr;
      TsShDr:    return m ? TsEx1Dr : TsShDr;
      TsEx1Dr:   return m ? TsUpdDr : TsPauseDr;
      TsPauseDr: return m ? TsEx2Dr : TsPauseDr;
      TsEx2Dr:   return m ? TsUpdDr : TsShDr;
      TsUpdDr:   return m ? TsSelDr : TsIdle;
      TsSelIr:   return m ? TsTlr   : TsCapIr;
      TsCapIr:   return m ? TsEx1Ir : TsShIr;
      TsShIr:    return m ? TsEx1Ir : TsShIr;
      TsEx1Ir:   return m ? TsUpdIr : TsPauseIr;
      TsPauseIr: return m ? TsEx2Ir : TsPauseIr;
      TsEx2Ir:   return m ? TsUpdIr : TsShIr;
      TsUpdIr:   return m ? TsSelDr : TsIdle;
      default:   return TsTlr;
    endcase
  endfunction

  always @(posedge tck) begin
    case (ts)
      TsTlr:   ir <= IrIdcode;
      TsCapDr: begin
        dr_sr <= (ir == IrIdcode) ? Idcode : ((ir == IrUser) ? user_in : 32'h0);
        byp   <= 1'b0;
      end
      TsShDr:  begin
        dr_sr <= {tdi, dr_sr[31:1]};
        byp   <= tdi;
      end
      TsUpdDr: if (ir == IrUser) user_out <= dr_sr;
      TsCapIr: ir_sr <= 4'b0001;
      TsShIr:  ir_sr <= {tdi, ir_sr[3:1]};
      TsUpdIr: ir <= ir_sr;
      default: ;
    endcase
    ts <= ts_next(ts, tms);
  end

  always @(negedge tck) begin
    if (ts == TsShDr) tdo <= (ir == IrIdcode || ir == IrUser) ? dr_sr[0] : byp;
    else if (ts == TsShIr) tdo <= ir_sr[0];
    else tdo <= 1'b0;
  end

  // ---------------- stimulus helper ----------------
  // Issues one command from a negedge; j counts posedges after the accepting edge.
  task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                         input logic [31:0] data, output logic [31:0] rdata,
                         output logic rerr, output int rsp_at, output int rdy_at,
                         output logic [63:0] tms_tr, output logic tmo);
    int n;
    tmo    = 1'b0;
    rdata  = 32'h0;
    rerr   = 1'b0;
    rsp_at = -1;
    rdy_at = -1;
    tms_tr = 64'h0;
    n      = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge tck);
      n++;
    end
    if (!bus.cmd_ready) begin
      tmo = 1'b1;
      return;
    end
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(negedge tck);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ~op;
    bus.cmd_len   = ~len;
    bus.cmd_data  = ~data;
    for (int j = 0; j < 100; j++) begin
      if (j < 64) tms_tr[j] = tms;
      if (bus.rsp_valid) begin
        rsp_at = j;
        rdata  = bus.rsp_data;
        rerr   = bus.rsp_err;
        break;
      end
      @(negedge tck);
    end
    if (rsp_at < 0) begin
      tmo = 1'b1;
      return;
    end
    for (int j = rsp_at; j < rsp_at + 10; j++) begin
      if (bus.cmd_ready) begin
        rdy_at = j;
        break;
      end
      @(negedge tck);
    end
    if (rdy_at < 0) tmo = 1'b1;
  endtask

  logic [31:0] rdata;
  logic        rerr;
  int          rsp_at;
  int          rdy_at;
  logic [63:0] tms_tr;
  logic        tmo;

  // ---------------- tests ----------------
  task automatic test_reset();
    int ones;
    int rdy;
    logic zero_seen;
    trst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_len = '0;
    bus.cmd_data = '0;
    repeat (3) @(negedge tck);
    total++; if (tms !== 1'b1) begin bad++; $display("FAIL reset_tms: got %b want 1", tms); end
    total++; if (tdi !== 1'b0) begin bad++; $display("FAIL reset_tdi: got %b want 0", tdi); end
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.cmd_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    trst = 1'b0;
    ones = 0;
    rdy = -1;
    zero_seen = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (tms === 1'b1 && !zero_seen) ones++;
      if (tms !== 1'b1) zero_seen = 1'b1;
      if (bus.cmd_ready) begin
        rdy = j;
        break;
      end
      @(negedge tck);
    end
    total++; if (ones !== 5) begin bad++; $display("FAIL init_ones: got %0d want 5", ones); end
    total++; if (rdy !== 6) begin bad++; $display("FAIL init_ready_at: got %0d want 6", rdy); end
    total++; if (ts !== TsIdle) begin bad++; $display("FAIL init_tap_state: got %0d want %0d", ts, TsIdle); end
  endtask

  task automatic test_idcode(input string tag);
    run_cmd(2'd0, 6'd32, 32'h0, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL %s_timeout: got %b want 0", tag, tmo); end
    total++; if (rdata !== 32'h12345157) begin bad++; $display("FAIL %s_data: got %h want 12345157", tag, rdata); end
    total++; if (rerr !== 1'b0) begin bad++; $display("FAIL %s_err: got %b want 0", tag, rerr); end
    total++; if (rsp_at !== 37) begin bad++; $display("FAIL %s_rsp_at: got %0d want 37", tag, rsp_at); end
    total++; if (rdy_at !== 38) begin bad++; $display("FAIL %s_ready_at: got %0d want 38", tag, rdy_at); end
  endtask

  task automatic test_user();
    run_cmd(2'd1, 6'd4, 32'h8, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL ir_user_timeout: got %b want 0", tmo); end
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL ir_user_data: got %h want 00000001", rdata); end
    total++; if (rsp_at !== 10) begin bad++; $display("FAIL ir_user_rsp_at: got %0d want 10", rsp_at); end
    total++; if (tms_tr[9:0] !== 10'h183) begin bad++; $display("FAIL ir_tms_seq: got %h want 183", tms_tr[9:0]); end
    total++; if (ir !== IrUser) begin bad++; $display("FAIL ir_user_loaded: got %h want 8", ir); end
    run_cmd(2'd0, 6'd32, 32'hDEADBEEF, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL dr_user_timeout: got %b want 0", tmo); end
    total++; if (rdata !== 32'h0BADF00D) begin bad++; $display("FAIL dr_user_data: got %h want 0badf00d", rdata); end
    total++; if (user_out !== 32'hDEADBEEF) begin bad++; $display("FAIL dr_user_update: got %h want deadbeef", user_out); end
  endtask

  task automatic test_bypass();
    run_cmd(2'd1, 6'd4, 32'hF, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL ir_bypass_data: got %h want 00000001", rdata); end
    run_cmd(2'd0, 6'd8, 32'hA5, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL bypass_timeout: got %b want 0", tmo); end
    total++; if (rdata !== 32'h4A) begin bad++; $display("FAIL bypass_data: got %h want 0000004a", rdata); end
    total++; if (rsp_at !== 13) begin bad++; $display("FAIL bypass_rsp_at: got %0d want 13", rsp_at); end
  endtask

  task automatic test_errors();
    logic [1:0]       ops  [3] = '{2'd0, 2'd0, 2'd3};
    logic [LEN_W-1:0] lens [3] = '{6'd0, 6'd33, 6'd8};
    for (int k = 0; k < 3; k++) begin
      run_cmd(ops[k], lens[k], 32'hFFFF_FFFF, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL err%0d_timeout: got %b want 0", k, tmo); end
      total++; if (rsp_at !== 0) begin bad++; $display("FAIL err%0d_rsp_at: got %0d want 0", k, rsp_at); end
      total++; if (rerr !== 1'b1) begin bad++; $display("FAIL err%0d_err: got %b want 1", k, rerr); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL err%0d_data: got %h want 0", k, rdata); end
      total++; if (rdy_at !== 1) begin bad++; $display("FAIL err%0d_ready_at: got %0d want 1", k, rdy_at); end
      total++; if (tms !== 1'b0 || tms_tr[0] !== 1'b0) begin bad++; $display("FAIL err%0d_tms: got %b/%b want 0/0", k, tms_tr[0], tms); end
    end
  endtask

  task automatic test_len1();
    run_cmd(2'd0, 6'd1, 32'h1, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL len1_timeout: got %b want 0", tmo); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL len1_data: got %h want 0", rdata); end
    total++; if (rsp_at !== 6) begin bad++; $display("FAIL len1_rsp_at: got %0d want 6", rsp_at); end
    total++; if (tms_tr[5:0] !== 6'h19) begin bad++; $display("FAIL len1_tms_seq: got %h want 19", tms_tr[5:0]); end
  endtask

  task automatic test_tap_reset();
    run_cmd(2'd2, 6'd1, 32'h0, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL tapreset_timeout: got %b want 0", tmo); end
    total++; if (rsp_at !== 6) begin bad++; $display("FAIL tapreset_rsp_at: got %0d want 6", rsp_at); end
    total++; if (rerr !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL tapreset_rsp: got err=%b data=%h want err=0 data=0", rerr, rdata); end
    total++; if (tms_tr[5:0] !== 6'h1F) begin bad++; $display("FAIL tapreset_tms_seq: got %h want 1f", tms_tr[5:0]); end
    total++; if (ir !== IrIdcode || ts !== TsIdle) begin bad++; $display("FAIL tapreset_tap: got ir=%h st=%0d want ir=1 st=%0d", ir, ts, TsIdle); end
  endtask

  task automatic test_abort();
    int n;
    int ones;
    int rdy;
    logic zero_seen;
    logic saw_rsp;
    // Select BYPASS so the reset has to restore IDCODE.
    run_cmd(2'd1, 6'd4, 32'hF, rdata, rerr, rsp_at, rdy_at, tms_tr, tmo);
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge tck);
      n++;
    end
    bus.cmd_op    = 2'd0;
    bus.cmd_len   = 6'd32;
    bus.cmd_data  = 32'h0;
    bus.cmd_valid = 1'b1;
    @(negedge tck);
    bus.cmd_valid = 1'b0;
    repeat (13) @(negedge tck); // bit 10 is on the pins
    trst = 1'b1;
    @(negedge tck);
    trst = 1'b0;
    ones = 0;
    rdy = -1;
    zero_seen = 1'b0;
    saw_rsp = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (bus.rsp_valid) saw_rsp = 1'b1;
      if (tms === 1'b1 && !zero_seen) ones++;
      if (tms !== 1'b1) zero_seen = 1'b1;
      if (bus.cmd_ready) begin
        rdy = j;
        break;
      end
      @(negedge tck);
    end
    total++; if (saw_rsp !== 1'b0) begin bad++; $display("FAIL abort_rsp: got %b want 0", saw_rsp); end
    total++; if (ones !== 5) begin bad++; $display("FAIL abort_ones: got %0d want 5", ones); end
    total++; if (rdy !== 6) begin bad++; $display("FAIL abort_ready_at: got %0d want 6", rdy); end
    test_idcode("after_abort");
  endtask

  initial begin
    test_reset();
    test_idcode("idcode");
    test_user();
    test_bypass();
    test_errors();
    test_len1();
    test_tap_reset();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
